// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: two-port round-robin access controller for a single-port RAM,
// with a full-memory clear sweep that runs at power-up and on request.
module ram_access_ctrl #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              wr_rd0,
   input  logic              wr_rd1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              clr_req,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              clr_done,
   output logic              ram_en,
   output logic              ram_rst,
   output logic              ram_wr_rd,
   output logic [7:0]        ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);
   typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, RESP} state_t;
   localparam logic [7:0] LAST = 8'((1 << ADDR_W) - 1);
   state_t state_q, state_d;
   logic last_gnt_q, last_gnt_d, clr_pend_q, clr_pend_d;
   logic gnt0_d, gnt1_d, rvalid0_d, rvalid1_d, busy_d, clr_done_d;
   logic ram_en_d, ram_rst_d, ram_wr_rd_d;
   logic [7:0] ram_addr_d;
   logic [DATA_W-1:0] ram_din_d;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         clr_pend_q <= 1'b1;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         rvalid0    <= 1'b0;
         rvalid1    <= 1'b0;
         busy       <= 1'b0;
         clr_done   <= 1'b0;
         ram_en     <= 1'b0;
         ram_rst    <= 1'b0;
         ram_wr_rd  <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         clr_pend_q <= clr_pend_d;
         gnt0       <= gnt0_d;
         gnt1       <= gnt1_d;
         rvalid0    <= rvalid0_d;
         rvalid1    <= rvalid1_d;
         busy       <= busy_d;
         clr_done   <= clr_done_d;
         ram_en     <= ram_en_d;
         ram_rst    <= ram_rst_d;
         ram_wr_rd  <= ram_wr_rd_d;
         ram_addr   <= ram_addr_d;
         ram_din    <= ram_din_d;
      end
   end
   // last_gnt doubles as the current winner: it only changes on entry to ISSUE
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      clr_pend_d = clr_pend_q | clr_req;
      case (state_q)
         IDLE: begin
            if (clr_pend_q | clr_req) begin
               state_d    = CLEAR;
               clr_pend_d = 1'b0;
            end else if (req0 | req1) begin
               state_d    = ISSUE;
               last_gnt_d = (req0 & req1) ? ~last_gnt_q : req1;
            end
         end
         CLEAR: begin
            clr_pend_d = 1'b0;
            state_d    = (ram_addr == LAST) ? IDLE : CLEAR;
         end
         ISSUE: state_d = ram_wr_rd ? IDLE : RESP;
         RESP:  state_d = IDLE;
      endcase
   end
   // outputs are registered, so they decode the state being entered
   always_comb begin
      ram_addr_d  = ram_addr;
      ram_din_d   = ram_din;
      ram_wr_rd_d = ram_wr_rd;
      if (state_d == CLEAR)
         ram_addr_d = (state_q == CLEAR) ? ram_addr + 8'd1 : 8'd0;
      else if (state_q == IDLE && state_d == ISSUE) begin
         ram_addr_d  = last_gnt_d ? 8'(addr1) : 8'(addr0);
         ram_din_d   = last_gnt_d ? wdata1 : wdata0;
         ram_wr_rd_d = last_gnt_d ? wr_rd1 : wr_rd0;
      end
      busy_d     = state_d != IDLE;
      ram_en_d   = state_d == CLEAR || state_d == ISSUE;
      ram_rst_d  = state_d == CLEAR;
      clr_done_d = state_d == CLEAR && ram_addr_d == LAST;
      gnt0_d     = state_d == ISSUE && !last_gnt_d;
      gnt1_d     = state_d == ISSUE && last_gnt_d;
      rvalid0_d  = state_d == RESP && !last_gnt_d;
      rvalid1_d  = state_d == RESP && last_gnt_d;
   end
   assign rdata = ram_dout;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb_ram_access_ctrl: directed bench for ram_access_ctrl with a behavioural RAM.
module tb_ram_access_ctrl;
   logic clk, rst, req0, req1, wr_rd0, wr_rd1, clr_req;
   logic [2:0] addr0, addr1;
   logic [3:0] wdata0, wdata1, rdata, ram_din, ram_dout;
   logic gnt0, gnt1, rvalid0, rvalid1, busy, clr_done, ram_en, ram_rst, ram_wr_rd;
   logic [7:0] ram_addr;
   logic [3:0] mem [256];
   logic [7:0] flags;
   int checks = 0, errors = 0;

   // flag layout: busy en rst done gnt0 gnt1 rvalid0 rvalid1
   assign flags = {busy, ram_en, ram_rst, clr_done, gnt0, gnt1, rvalid0, rvalid1};

   ram_access_ctrl #(.ADDR_W(3), .DATA_W(4)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wr_rd0(wr_rd0), .wr_rd1(wr_rd1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .clr_req(clr_req),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
      .busy(busy), .clr_done(clr_done), .ram_en(ram_en), .ram_rst(ram_rst),
      .ram_wr_rd(ram_wr_rd), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   initial for (int i = 0; i < 256; i++) mem[i] = 4'h5;

   always @(posedge clk)
      if (ram_en) begin
         if (ram_rst) mem[ram_addr] <= 4'h0;
         else if (ram_wr_rd) mem[ram_addr] <= ram_din;
         else ram_dout <= mem[ram_addr];
      end

   task automatic test_reset();
      rst = 0; req0 = 0; req1 = 0; wr_rd0 = 0; wr_rd1 = 0; clr_req = 0;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      repeat (2) @(negedge clk);
      checks++; if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags got %h exp 00", flags); end
      checks++; if (ram_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", ram_addr); end
      rst = 1;
   endtask

   task automatic test_power_clear();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++; if (flags !== (k == 7 ? 8'hF0 : 8'hE0)) begin errors++; $display("FAIL pclr_flags k=%0d got %h exp %h", k, flags, (k == 7 ? 8'hF0 : 8'hE0)); end
         checks++; if (ram_addr !== 8'(k)) begin errors++; $display("FAIL pclr_addr got %0d exp %0d", ram_addr, k); end
      end
      @(negedge clk);
      checks++; if (flags !== 8'h00) begin errors++; $display("FAIL pclr_idle got %h exp 00", flags); end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp;
      req0 = 1; req1 = 1; wr_rd0 = 1; wr_rd1 = 1; addr0 = 1; addr1 = 2; wdata0 = 6; wdata1 = 9;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         exp = (i % 4 == 0) ? 8'hC8 : (i % 4 == 2) ? 8'hC4 : 8'h00;
         checks++; if (flags !== exp) begin errors++; $display("FAIL rr_flags i=%0d got %h exp %h", i, flags, exp); end
         if (i % 2 == 0) begin
            checks++; if ({ram_addr, ram_din} !== (i % 4 == 0 ? 12'h016 : 12'h029)) begin errors++; $display("FAIL rr_addr_din i=%0d got %h exp %h", i, {ram_addr, ram_din}, (i % 4 == 0 ? 12'h016 : 12'h029)); end
         end
      end
      req0 = 0; req1 = 0;
   endtask

   task automatic test_write_read();
      req0 = 1; wr_rd0 = 1; addr0 = 3; wdata0 = 4'hA;
      @(negedge clk);
      checks++; if (flags !== 8'hC8) begin errors++; $display("FAIL wr_issue got %h exp c8", flags); end
      checks++; if ({ram_wr_rd, ram_addr, ram_din} !== 13'h103A) begin errors++; $display("FAIL wr_bus got %h exp 103a", {ram_wr_rd, ram_addr, ram_din}); end
      wr_rd0 = 0;
      @(negedge clk);
      checks++; if (flags !== 8'h00) begin errors++; $display("FAIL wr_gap got %h exp 00", flags); end
      @(negedge clk);
      checks++; if (flags !== 8'hC8) begin errors++; $display("FAIL rd_issue got %h exp c8", flags); end
      checks++; if ({ram_wr_rd, ram_addr} !== 9'h003) begin errors++; $display("FAIL rd_bus got %h exp 003", {ram_wr_rd, ram_addr}); end
      req0 = 0;
      @(negedge clk);
      checks++; if (flags !== 8'h82) begin errors++; $display("FAIL rd_resp got %h exp 82", flags); end
      checks++; if (rdata !== 4'hA) begin errors++; $display("FAIL rd_data got %h exp a", rdata); end
      @(negedge clk);
      checks++; if (flags !== 8'h00) begin errors++; $display("FAIL rd_idle got %h exp 00", flags); end
   endtask

   task automatic test_clr_during_read();
      req0 = 1; wr_rd0 = 0; addr0 = 3;
      @(negedge clk);
      checks++; if (flags !== 8'hC8) begin errors++; $display("FAIL cr_issue got %h exp c8", flags); end
      clr_req = 1; req0 = 0;
      @(negedge clk);
      clr_req = 0;
      checks++; if (flags !== 8'h82) begin errors++; $display("FAIL cr_resp got %h exp 82", flags); end
      checks++; if (rdata !== 4'hA) begin errors++; $display("FAIL cr_data got %h exp a", rdata); end
      @(negedge clk);
      checks++; if (flags !== 8'h00) begin errors++; $display("FAIL cr_idle got %h exp 00", flags); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++; if ({flags, ram_addr} !== {(k == 7 ? 8'hF0 : 8'hE0), 8'(k)}) begin errors++; $display("FAIL cr_sweep k=%0d got %h exp %h", k, {flags, ram_addr}, {(k == 7 ? 8'hF0 : 8'hE0), 8'(k)}); end
      end
      @(negedge clk);
      checks++; if (flags !== 8'h00) begin errors++; $display("FAIL cr_done_idle got %h exp 00", flags); end
      // tie after the sweep: port 0 was served last, so port 1 must win
      req0 = 1; wr_rd0 = 0; addr0 = 3; req1 = 1; wr_rd1 = 0; addr1 = 1;
      @(negedge clk);
      checks++; if ({flags, ram_addr} !== 16'hC401) begin errors++; $display("FAIL cr_tie got %h exp c401", {flags, ram_addr}); end
      req1 = 0;
      @(negedge clk);
      checks++; if ({flags, rdata} !== 12'h810) begin errors++; $display("FAIL cr_rd1 got %h exp 810", {flags, rdata}); end
      @(negedge clk);
      checks++; if (flags !== 8'h00) begin errors++; $display("FAIL cr_gap got %h exp 00", flags); end
      @(negedge clk);
      checks++; if ({flags, ram_addr} !== 16'hC803) begin errors++; $display("FAIL cr_rd0_issue got %h exp c803", {flags, ram_addr}); end
      req0 = 0;
      @(negedge clk);
      checks++; if ({flags, rdata} !== 12'h820) begin errors++; $display("FAIL cr_rd0 got %h exp 820", {flags, rdata}); end
      @(negedge clk);
      checks++; if (flags !== 8'h00) begin errors++; $display("FAIL cr_end got %h exp 00", flags); end
   endtask

   task automatic test_reset_mid_clear();
      clr_req = 1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         clr_req = 0;
         checks++; if ({flags, ram_addr} !== {8'hE0, 8'(k)}) begin errors++; $display("FAIL rm_sweep k=%0d got %h exp %h", k, {flags, ram_addr}, {8'hE0, 8'(k)}); end
      end
      rst = 0;
      #1;
      checks++; if ({flags, ram_addr} !== 16'h0000) begin errors++; $display("FAIL rm_async got %h exp 0000", {flags, ram_addr}); end
      @(negedge clk);
      checks++; if ({flags, ram_addr} !== 16'h0000) begin errors++; $display("FAIL rm_held got %h exp 0000", {flags, ram_addr}); end
      rst = 1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++; if ({flags, ram_addr} !== {(k == 7 ? 8'hF0 : 8'hE0), 8'(k)}) begin errors++; $display("FAIL rm_restart k=%0d got %h exp %h", k, {flags, ram_addr}, {(k == 7 ? 8'hF0 : 8'hE0), 8'(k)}); end
      end
      @(negedge clk);
      checks++; if (flags !== 8'h00) begin errors++; $display("FAIL rm_idle got %h exp 00", flags); end
   endtask

   task automatic test_req_during_clear();
      clr_req = 1; req1 = 1; wr_rd1 = 1; addr1 = 5; wdata1 = 3;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         clr_req = (k == 2);
         checks++; if ({flags, ram_addr} !== {(k == 7 ? 8'hF0 : 8'hE0), 8'(k)}) begin errors++; $display("FAIL rc_sweep k=%0d got %h exp %h", k, {flags, ram_addr}, {(k == 7 ? 8'hF0 : 8'hE0), 8'(k)}); end
      end
      @(negedge clk);
      checks++; if (flags !== 8'h00) begin errors++; $display("FAIL rc_idle got %h exp 00", flags); end
      @(negedge clk);
      checks++; if ({flags, ram_addr} !== 16'hC405) begin errors++; $display("FAIL rc_gnt1 got %h exp c405", {flags, ram_addr}); end
      req1 = 0;
      repeat (2) begin
         @(negedge clk);
         checks++; if (flags !== 8'h00) begin errors++; $display("FAIL rc_no_resweep got %h exp 00", flags); end
      end
   endtask

   initial begin
      test_reset();
      test_power_clear();
      test_round_robin();
      test_write_read();
      test_clr_during_read();
      test_reset_mid_clear();
      test_req_during_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
